// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the rvsimple load/store unit: funct3 codes, FSM states
// and request legality/alignment helpers.
package rv_lsu_pkg;

  localparam int unsigned LSU_WIDTH = 32;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2,
    LSU_ERR    = 2'd3
  } lsu_state_t;

  // Stores have no unsigned variants, so only the low three codes are legal.
  function automatic logic lsu_legal(input logic write, input logic [2:0] funct3);
    if (write) begin
      return (funct3 == LSU_SB) || (funct3 == LSU_SH) || (funct3 == LSU_SW);
    end
    return (funct3 == LSU_LB) || (funct3 == LSU_LH) || (funct3 == LSU_LW) ||
           (funct3 == LSU_LBU) || (funct3 == LSU_LHU);
  endfunction

  function automatic logic lsu_aligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b01:   return !addr[0];
      2'b10:   return addr == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_data_formatter.sv
// Picks the addressed byte/halfword out of a bus word and sign- or zero-extends it.
module load_data_formatter
  import rv_lsu_pkg::*;
(
  input  logic [LSU_WIDTH-1:0] rdata,
  input  logic [1:0]           addr,
  input  logic [2:0]           funct3,
  output logic [LSU_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (funct3)
      LSU_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LSU_LH:  data = {{16{half_sel[15]}}, half_sel};
      LSU_LBU: data = {24'h000000, byte_sel};
      LSU_LHU: data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access unit: one request at a time, word-addressed bus
// with byte enables and wait states, formatted load data back to writeback.
module load_store_unit
  import rv_lsu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [3:0]            bus_byteenable,
  output logic [WIDTH-1:0]      bus_wdata,
  input  logic                  bus_wait,
  input  logic [WIDTH-1:0]      bus_rdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_error,
  output logic                  busy
);

  lsu_state_t       state;
  logic [1:0]       lane_q;
  logic [2:0]       funct3_q;
  logic             write_q;
  logic             req_ok_c;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] load_c;

  assign req_ready = (state == LSU_IDLE);
  assign busy      = (state != LSU_IDLE);
  assign req_ok_c  = lsu_legal(req_write, req_funct3) && lsu_aligned(req_funct3, req_addr[1:0]);

  // Byte lanes and lane-replicated store data for the incoming request.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << req_addr[1:0];
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  load_data_formatter u_load_data_formatter (
    .rdata  (bus_rdata),
    .addr   (lane_q),
    .funct3 (funct3_q),
    .data   (load_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= LSU_IDLE;
      lane_q         <= 2'b00;
      funct3_q       <= 3'b000;
      write_q        <= 1'b0;
      bus_addr       <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_byteenable <= 4'b0000;
      bus_wdata      <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_error      <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            lane_q   <= req_addr[1:0];
            funct3_q <= req_funct3;
            write_q  <= req_write;
            if (!req_ok_c) begin
              // Faulting requests never touch the bus.
              state     <= LSU_ERR;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state          <= LSU_ACCESS;
              bus_addr       <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus_read       <= !req_write;
              bus_write      <= req_write;
              bus_byteenable <= be_c;
              bus_wdata      <= wdata_c;
            end
          end
        end
        LSU_ACCESS: begin
          if (!bus_wait) begin
            state     <= LSU_RESP;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_data  <= write_q ? '0 : load_c;
          end
        end
        default: begin
          state     <= LSU_IDLE;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit and the standalone load_data_formatter.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_wdata;
  logic        bus_wait = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;

  logic [31:0] fm_rdata;
  logic [1:0]  fm_addr;
  logic [2:0]  fm_funct3;
  logic [31:0] fm_data;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  load_store_unit #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .bus_addr(bus_addr), .bus_read(bus_read),
    .bus_write(bus_write), .bus_byteenable(bus_byteenable), .bus_wdata(bus_wdata),
    .bus_wait(bus_wait), .bus_rdata(bus_rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy)
  );

  load_data_formatter u_fmt (
    .rdata(fm_rdata), .addr(fm_addr), .funct3(fm_funct3), .data(fm_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference behaviour derived from access size and offset arithmetic.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic err, output logic [3:0] be,
                                output logic [31:0] bw, output logic [31:0] rdat);
    int size;
    int off;
    logic legal;
    logic [31:0] mask;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 < 3'd3) : (f3 < 3'd3 || f3 == 3'd4 || f3 == 3'd5);
    off   = int'(a % 4);
    err   = !legal || (off % size != 0);
    be    = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) bw[8*i +: 8] = wd[8*(i % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
    v = (rd >> (8 * off)) & mask;
    if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~mask;
    rdat = (err || w) ? 32'h0 : v;
  endfunction

  // Runs one request from an IDLE cycle until the unit is back in IDLE.
  task automatic run_txn(input string name, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input logic hold);
    logic err;
    logic [3:0] be;
    logic [31:0] bw;
    logic [31:0] rdat;
    model(w, f3, a, wd, rd, err, be, bw, rdat);
    check({name, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    bus_rdata = rd;
    step();
    if (!hold) req_valid = 1'b0;
    if (err) begin
      check({name, ".err_valid"}, 32'(rsp_valid), 32'd1);
      check({name, ".err_flag"}, 32'(rsp_error), 32'd1);
      check({name, ".err_data"}, rsp_data, 32'h0);
      check({name, ".err_strobe"}, 32'({bus_read, bus_write}), 32'd0);
      step();
      check({name, ".err_strobe2"}, 32'({bus_read, bus_write}), 32'd0);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        check({name, ".rd"}, 32'(bus_read), 32'(!w));
        check({name, ".wr"}, 32'(bus_write), 32'(w));
        check({name, ".addr"}, bus_addr, {a[31:2], 2'b00});
        check({name, ".be"}, 32'(bus_byteenable), 32'(be));
        if (w) check({name, ".wdata"}, bus_wdata, bw);
        check({name, ".no_rsp"}, 32'(rsp_valid), 32'd0);
        if (hold) check({name, ".not_ready"}, 32'(req_ready), 32'd0);
        bus_wait = (k < waits);
        step();
      end
      bus_wait = 1'b0;
      check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, ".rsp_error"}, 32'(rsp_error), 32'd0);
      check({name, ".rsp_data"}, rsp_data, rdat);
      check({name, ".strobe_off"}, 32'({bus_read, bus_write}), 32'd0);
      req_valid = 1'b0;
      step();
    end
    req_valid = 1'b0;
    check({name, ".idle_rsp"}, 32'(rsp_valid), 32'd0);
    check({name, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  addr;
    logic [2:0]  funct3;
    logic [31:0] exp;
  } fmt_vec_t;

  initial begin
    fmt_vec_t vecs[12];
    vecs[0]  = '{32'h8012_3456, 2'd3, 3'b000, 32'hFFFF_FF80};
    vecs[1]  = '{32'h8012_3456, 2'd3, 3'b100, 32'h0000_0080};
    vecs[2]  = '{32'h8012_3456, 2'd0, 3'b000, 32'h0000_0056};
    vecs[3]  = '{32'h8012_3456, 2'd1, 3'b000, 32'h0000_0034};
    vecs[4]  = '{32'h8012_3456, 2'd2, 3'b001, 32'hFFFF_8012};
    vecs[5]  = '{32'h8012_3456, 2'd2, 3'b101, 32'h0000_8012};
    vecs[6]  = '{32'h8012_3456, 2'd0, 3'b001, 32'h0000_3456};
    vecs[7]  = '{32'hDEAD_BEEF, 2'd0, 3'b010, 32'hDEAD_BEEF};
    vecs[8]  = '{32'h0000_F00D, 2'd0, 3'b101, 32'h0000_F00D};
    vecs[9]  = '{32'h0000_F00D, 2'd0, 3'b001, 32'hFFFF_F00D};
    vecs[10] = '{32'h12FF_34AB, 2'd2, 3'b000, 32'hFFFF_FFFF};
    vecs[11] = '{32'h12FF_34AB, 2'd1, 3'b100, 32'h0000_0034};

    #1;
    check("reset.read", 32'(bus_read), 32'd0);
    check("reset.write", 32'(bus_write), 32'd0);
    check("reset.addr", bus_addr, 32'h0);
    check("reset.be", 32'(bus_byteenable), 32'd0);
    check("reset.wdata", bus_wdata, 32'h0);
    check("reset.rsp", 32'({rsp_valid, rsp_error}), 32'd0);
    check("reset.rsp_data", rsp_data, 32'h0);
    step();
    step();
    reset = 1'b0;
    check("post_reset.ready", 32'(req_ready), 32'd1);
    check("post_reset.busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      fm_rdata = vecs[i].rdata; fm_addr = vecs[i].addr; fm_funct3 = vecs[i].funct3;
      #1;
      check($sformatf("fmt[%0d]", i), fm_data, vecs[i].exp);
    end

    run_txn("lw_1000", 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    check("lw_1000.literal", rsp_data, 32'h0);
    run_txn("lb_1003", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1'b0);
    run_txn("lbu_1003", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1'b0);
    run_txn("sh_2002", 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h1111_2222, 0, 1'b0);
    run_txn("lw_mis", 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0, 1'b0);
    run_txn("f3_011", 1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 1'b0);
    run_txn("lhu_wait", 1'b0, 3'b101, 32'h0000_3000, 32'h0, 32'h0000_F00D, 3, 1'b1);

    // Fixed-literal checks of the test-plan sequences, independent of the model.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0000_1003;
    bus_rdata = 32'h8012_3456;
    step(); req_valid = 1'b0;
    check("lb_lit.be", 32'(bus_byteenable), 32'h8);
    step();
    check("lb_lit.data", rsp_data, 32'hFFFF_FF80);
    step();
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0000_2002;
    req_wdata = 32'h0000_ABCD;
    step(); req_valid = 1'b0;
    check("sh_lit.addr", bus_addr, 32'h0000_2000);
    check("sh_lit.be", 32'(bus_byteenable), 32'hC);
    check("sh_lit.wdata", bus_wdata, 32'hABCD_ABCD);
    step();
    check("sh_lit.rsp", 32'({rsp_valid, rsp_error}), 32'd2);
    step();

    // Reset during a pending wait state abandons the access silently.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_4000;
    bus_wait = 1'b1;
    step(); req_valid = 1'b0;
    check("rst_mid.strobe", 32'(bus_read), 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("rst_mid.read", 32'(bus_read), 32'd0);
    check("rst_mid.be", 32'(bus_byteenable), 32'd0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0; bus_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid.no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn("lw_after_rst", 1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              ra, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
